// File: rtl/ifft4_stream.sv
// Purpose: 4-point radix-2 inverse FFT over valid/ready streams (bins in X0..X3, samples out x0..x3).
// Latency: X3 accepted on cycle T -> x0 presented on cycle T+3 (two registered butterfly stages).
// Backpressure: in_ready only in LOAD; outputs held stable while out_valid && !out_ready.
module ifft4_stream #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int H = WIDTH / 2;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        STAGE1 = 2'd1,
        STAGE2 = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       cnt;
    logic [1:0]       idx;
    logic [WIDTH-1:0] bin [4];
    logic [WIDTH-1:0] a0, a1, b0, b1;
    logic [WIDTH-1:0] xs [4];
    logic [WIDTH-1:0] a0_c, a1_c, b0_c, b1_c;
    logic [WIDTH-1:0] x_c [4];
    logic             in_hs;
    logic             out_hs;

    // Half-width add/subtract with one guard bit, then floor-halve back to H bits.
    // The guard bit makes the halved result always representable, so no saturation.
    function automatic logic [H-1:0] half_op(input logic [H-1:0] p, input logic [H-1:0] q,
                                             input logic sub);
        logic [H:0] s;
        if (sub) s = {p[H-1], p} - {q[H-1], q};
        else     s = {p[H-1], p} + {q[H-1], q};
        return s[H:1];
    endfunction

    function automatic logic [H-1:0] re(input logic [WIDTH-1:0] v);
        return v[WIDTH-1:H];
    endfunction

    function automatic logic [H-1:0] im(input logic [WIDTH-1:0] v);
        return v[H-1:0];
    endfunction

    assign in_ready = (state == LOAD);
    assign busy     = (state != LOAD);
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // First butterfly stage: pair even bins and odd bins.
    always_comb begin
        a0_c = {half_op(re(bin[0]), re(bin[2]), 1'b0), half_op(im(bin[0]), im(bin[2]), 1'b0)};
        a1_c = {half_op(re(bin[0]), re(bin[2]), 1'b1), half_op(im(bin[0]), im(bin[2]), 1'b1)};
        b0_c = {half_op(re(bin[1]), re(bin[3]), 1'b0), half_op(im(bin[1]), im(bin[3]), 1'b0)};
        b1_c = {half_op(re(bin[1]), re(bin[3]), 1'b1), half_op(im(bin[1]), im(bin[3]), 1'b1)};
    end

    // Second butterfly stage; the +j twiddle on b1 becomes a real/imag swap folded
    // into the add/sub choice, so no negation (and no -min overflow) is ever formed.
    always_comb begin
        x_c[0] = {half_op(re(a0), re(b0), 1'b0), half_op(im(a0), im(b0), 1'b0)};
        x_c[2] = {half_op(re(a0), re(b0), 1'b1), half_op(im(a0), im(b0), 1'b1)};
        x_c[1] = {half_op(re(a1), im(b1), 1'b1), half_op(im(a1), re(b1), 1'b0)};
        x_c[3] = {half_op(re(a1), im(b1), 1'b0), half_op(im(a1), re(b1), 1'b1)};
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nxt;
    end

    // Next-state logic: load four bins, two compute cycles, emit four samples.
    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_hs && cnt == 2'd3) state_nxt = STAGE1;
            STAGE1:  state_nxt = STAGE2;
            STAGE2:  state_nxt = EMIT;
            EMIT:    if (out_hs && idx == 2'd3) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    // Data storage: bins, stage-1 results and output samples need no reset since
    // they are always written before being read within a frame.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_hs) bin[cnt] <= in_data;
        if (state == STAGE1) begin
            a0 <= a0_c;
            a1 <= a1_c;
            b0 <= b0_c;
            b1 <= b1_c;
        end
        if (state == STAGE2) begin
            for (int i = 0; i < 4; i++) xs[i] <= x_c[i];
        end
    end

    // Counters and the registered output stream.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 2'd0;
            idx       <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_hs) cnt <= cnt + 2'd1;
                end
                STAGE2: begin
                    out_valid <= 1'b1;
                    out_data  <= x_c[0];
                    out_last  <= 1'b0;
                    idx       <= 2'd0;
                end
                EMIT: begin
                    if (out_hs) begin
                        if (idx == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            idx      <= idx + 2'd1;
                            out_data <= xs[idx + 2'd1];
                            out_last <= (idx == 2'd2);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
